// File: rtl/memory_access.sv
// Memory stage of the 5-stage MIPS pipeline: big-endian loads/stores over a
// req/ack data bus, HILO forwarding, and the memory->writeback latch.
module memory_access #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  aluop_input,
  input  logic [31:0] mem_addr_input,
  input  logic [31:0] regOp2_input,
  input  logic [4:0]  dest_addr,
  input  logic        write_or_not,
  input  logic [31:0] wdata_input,
  input  logic        execute_HILO_enabler,
  input  logic [31:0] execute_HILO_HI,
  input  logic [31:0] execute_HILO_LO,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_sel,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic        stall_request,
  output logic        memory_HILO_enabler,
  output logic [31:0] memory_HILO_HI,
  output logic [31:0] memory_HILO_LO,
  output logic [4:0]  memory2writeback_dest_addr,
  output logic        memory2writeback_write_or_not,
  output logic [31:0] memory2writeback_wdata,
  output logic        memory2writeback_HILO_enabler,
  output logic [31:0] memory2writeback_HILO_HI,
  output logic [31:0] memory2writeback_HILO_LO,
  output logic        addr_error,
  output logic        bus_error,
  output logic        state_debug
);

  localparam logic [7:0] ALUOP_LB  = 8'b11100000;
  localparam logic [7:0] ALUOP_LBU = 8'b11100100;
  localparam logic [7:0] ALUOP_LH  = 8'b11100001;
  localparam logic [7:0] ALUOP_LHU = 8'b11100101;
  localparam logic [7:0] ALUOP_LW  = 8'b11100011;
  localparam logic [7:0] ALUOP_SB  = 8'b11101000;
  localparam logic [7:0] ALUOP_SH  = 8'b11101001;
  localparam logic [7:0] ALUOP_SW  = 8'b11101011;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  localparam int CW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic {IDLE, BUS} state_t;

  state_t         state, state_next;
  logic [CW-1:0]  cnt;
  logic           is_load, is_store, is_mem, ld_signed, misaligned;
  logic [1:0]     size;
  logic [1:0]     off;
  logic [3:0]     lane_sel;
  logic [31:0]    store_data, load_data;
  logic [7:0]     ld_byte;
  logic [15:0]    ld_half;
  logic           wb_we;
  logic [31:0]    wb_data;

  assign off = mem_addr_input[1:0];

  always_comb begin
    is_load   = 1'b0;
    is_store  = 1'b0;
    ld_signed = 1'b0;
    size      = SZ_WORD;
    case (aluop_input)
      ALUOP_LB:  begin is_load = 1'b1; ld_signed = 1'b1; size = SZ_BYTE; end
      ALUOP_LBU: begin is_load = 1'b1; size = SZ_BYTE; end
      ALUOP_LH:  begin is_load = 1'b1; ld_signed = 1'b1; size = SZ_HALF; end
      ALUOP_LHU: begin is_load = 1'b1; size = SZ_HALF; end
      ALUOP_LW:  is_load = 1'b1;
      ALUOP_SB:  begin is_store = 1'b1; size = SZ_BYTE; end
      ALUOP_SH:  begin is_store = 1'b1; size = SZ_HALF; end
      ALUOP_SW:  is_store = 1'b1;
      default:   ;
    endcase
  end

  assign is_mem     = is_load | is_store;
  assign misaligned = ((size == SZ_HALF) && off[0]) || ((size == SZ_WORD) && (off != 2'b00));

  // Big-endian lanes: byte offset 0 lives in bits 31:24 (bus_sel bit 3).
  always_comb begin
    lane_sel   = 4'b1111;
    store_data = regOp2_input;
    ld_byte    = bus_rdata[31:24];
    case (off)
      2'd0: ld_byte = bus_rdata[31:24];
      2'd1: ld_byte = bus_rdata[23:16];
      2'd2: ld_byte = bus_rdata[15:8];
      2'd3: ld_byte = bus_rdata[7:0];
      default: ;
    endcase
    ld_half   = off[1] ? bus_rdata[15:0] : bus_rdata[31:16];
    load_data = bus_rdata;
    if (size == SZ_BYTE) begin
      lane_sel   = 4'b1000 >> off;
      store_data = {4{regOp2_input[7:0]}};
      load_data  = {{24{ld_signed & ld_byte[7]}}, ld_byte};
    end else if (size == SZ_HALF) begin
      lane_sel   = off[1] ? 4'b0011 : 4'b1100;
      store_data = {2{regOp2_input[15:0]}};
      load_data  = {{16{ld_signed & ld_half[15]}}, ld_half};
    end
  end

  // Bus handshake: bus_req rises in BUS and stays high with address, sel, we
  // and wdata stable until the cycle bus_ack=1 (rdata valid that cycle); the
  // access completes at that edge and bus_req drops for at least one cycle.
  always_comb begin
    state_next    = state;
    stall_request = 1'b0;
    bus_req       = 1'b0;
    addr_error    = 1'b0;
    bus_error     = 1'b0;
    wb_we         = write_or_not;
    wb_data       = wdata_input;
    case (state)
      IDLE: begin
        if (is_mem) begin
          if (misaligned) begin
            addr_error = 1'b1;
            wb_we      = 1'b0;
          end else begin
            stall_request = 1'b1;
            state_next    = BUS;
          end
        end
      end
      BUS: begin
        bus_req = 1'b1;
        if (bus_ack) begin
          state_next = IDLE;
          if (is_load) wb_data = load_data;
          else         wb_we   = 1'b0;
        end else if (cnt == CNT_LAST) begin
          bus_error  = 1'b1;
          wb_we      = 1'b0;
          state_next = IDLE;
        end else begin
          stall_request = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus_we      = bus_req & is_store;
  assign bus_sel     = bus_req ? lane_sel : 4'b0000;
  assign bus_addr    = bus_req ? {mem_addr_input[31:2], 2'b00} : 32'h0;
  assign bus_wdata   = bus_req ? store_data : 32'h0;
  assign state_debug = (state == BUS);

  assign memory_HILO_enabler = execute_HILO_enabler;
  assign memory_HILO_HI      = execute_HILO_HI;
  assign memory_HILO_LO      = execute_HILO_LO;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= (state == BUS && state_next == BUS) ? cnt + 1'b1 : '0;
    end
  end

  // A stalled cycle feeds a bubble to writeback.
  always_ff @(posedge clk or posedge rst) begin
    if (rst || stall_request) begin
      memory2writeback_dest_addr    <= 5'd0;
      memory2writeback_write_or_not <= 1'b0;
      memory2writeback_wdata        <= 32'h0;
      memory2writeback_HILO_enabler <= 1'b0;
      memory2writeback_HILO_HI      <= 32'h0;
      memory2writeback_HILO_LO      <= 32'h0;
    end else begin
      memory2writeback_dest_addr    <= dest_addr;
      memory2writeback_write_or_not <= wb_we;
      memory2writeback_wdata        <= wb_data;
      memory2writeback_HILO_enabler <= execute_HILO_enabler;
      memory2writeback_HILO_HI      <= execute_HILO_HI;
      memory2writeback_HILO_LO      <= execute_HILO_LO;
    end
  end

endmodule

// File: doc/memory_access.md
Name: memory_access

Overview:
- Memory stage of the 5-stage MIPS pipeline. Sits between the execute/memory pipeline latch and the writeback latch.
- Consumes the execute stage's memory-side outputs: ALU op, effective address, store data, result and HILO update.
- Performs loads and stores on a single-master req/ack data bus, with byte-lane steering and sign/zero extension.
- Drives pipeline stall, the combinational HILO forwarding path back to execute, and the registered writeback-side outputs.

Parameters:
- TIMEOUT_CYCLES, 16, bus cycles to wait for bus_ack before the access is aborted (min 1).

Ports:
- clk  input  1  pipeline clock.
- rst  input  1  asynchronous active-high reset.
- aluop_input  input  8  ALU op; load/store codes ALUOP_LB/LBU/LH/LHU/LW/SB/SH/SW from defineOperator.v.
- mem_addr_input  input  32  effective address.
- regOp2_input  input  32  store data.
- dest_addr  input  5  destination register.
- write_or_not  input  1  register write enable.
- wdata_input  input  32  execute result for non-load ops.
- execute_HILO_enabler / execute_HILO_HI / execute_HILO_LO  input  1/32/32  HILO update from execute.
- bus_req  output  1  access request.
- bus_we  output  1  1 = store.
- bus_addr  output  32  word-aligned address, {addr[31:2],2'b00}.
- bus_sel  output  4  byte lanes; bit3 = bits 31:24.
- bus_wdata  output  32  store data, lane-replicated.
- bus_ack  input  1  access complete; rdata valid in the same cycle.
- bus_rdata  input  32  read data.
- stall_request  output  1  freeze upstream stages and hold this stage's inputs.
- memory_HILO_enabler / memory_HILO_HI / memory_HILO_LO  output  1/32/32  combinational forward of the execute_HILO_* inputs.
- memory2writeback_dest_addr  output  5  registered.
- memory2writeback_write_or_not  output  1  registered.
- memory2writeback_wdata  output  32  registered.
- memory2writeback_HILO_enabler / _HI / _LO  output  1/32/32  registered.
- addr_error  output  1  one-cycle pulse: misaligned access.
- bus_error  output  1  one-cycle pulse: bus timeout.

Behaviour:
- Reset (asynchronous, rst=1): every registered output = 0; bus_req=0, bus_we=0, bus_sel=0; FSM = IDLE; timeout counter = 0. Reset mid-access drops bus_req immediately and the access is abandoned.
- Byte order is big-endian. Byte offset 0 maps to bus_sel 4'b1000; halfword offset 0 maps to 4'b1100 and offset 2 to 4'b0011; word maps to 4'b1111.
- Alignment: halfword access requires addr[0]=0; word access requires addr[1:0]=0.
  - A misaligned access never asserts bus_req.
  - addr_error pulses for one cycle.
  - The op passes to writeback with write_or_not forced to 0. No stall.
- Store data: SB uses {4{rt[7:0]}}, SH uses {2{rt[15:0]}}, SW uses rt.
- Load data: selects the addressed lane. LB/LH sign-extend; LBU/LHU zero-extend.
- FSM states:
  - IDLE:
    - Non-memory op: stall_request=0; the writeback latch loads the inputs at the next edge (1-cycle latency).
    - Aligned memory op: stall_request=1 combinationally; next state BUS.
  - BUS: bus_req=1, with address, sel, we and wdata held stable; the counter increments each cycle.
    - bus_ack=1: stall_request=0 in that cycle. memory2writeback_wdata gets the extended rdata for loads, or wdata_input for stores. Store write_or_not goes to 0. Next state IDLE; bus_req falls at that edge.
    - Counter reaches TIMEOUT_CYCLES with no ack: bus_error pulses and the op retires with write_or_not=0. Next state IDLE.
- Minimum load/store latency: 2 cycles (the request edge plus an ack in the first BUS cycle).
- A back-to-back memory op re-enters BUS after one IDLE cycle. bus_req is deasserted for at least one cycle between accesses.
- bus_ack while in IDLE is ignored.
- HILO:
  - memory_HILO_* forward combinationally, including during stall.
  - memory2writeback_HILO_* register alongside the other writeback outputs and update only when stall_request=0.
- While stall_request=1, the writeback latch loads a bubble: write_or_not=0, HILO_enabler=0.

Test Plan:
- Reset asserted asynchronously mid-BUS with a load outstanding -> bus_req=0 immediately; all outputs 0; next op starts from IDLE.
- LW addr 0x100, ack after 3 cycles with rdata 0xDEADBEEF -> bus_sel=1111; stall high 3 cycles; wb_wdata=0xDEADBEEF, write_or_not=1.
- LB addr 0x103 and LBU addr 0x103, rdata 0x000000F0 -> sel=0001; results 0xFFFFFFF0 and 0x000000F0.
- SH addr 0x202, rt=0x1234ABCD -> bus_we=1, sel=0011, wdata=0xABCDABCD; wb write_or_not=0.
- LW addr 0x101 -> no bus_req; addr_error pulses once; no stall; write_or_not=0.
- TIMEOUT_CYCLES=4, ack never arrives -> bus_error after 4 BUS cycles; stall released; MULT HILO update behind it reaches memory2writeback_HILO_* next edge.
